fsqrt_stream: RTL and testbench

Valid/ready streaming wrapper around the fixed-latency `fsqrt` pipeline. It accepts tagged single-precision operands from the FPU issue logic and drives them into `fsqrt`. It captures each result when it emerges and applies IEEE special-case fixups (zero, negative, inf, NaN) that the core does not handle. Results are buffered in an in-order FIFO so the consumer may stall without losing data. It sits between the issue stage and writeback, with `fsqrt` as its only datapath neighbour.

---
 rtl/fsqrt_stream.sv | 191 +++++++++++++++++++
 tb/tb_fsqrt_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_stream.sv
// fsqrt_stream: valid/ready streaming wrapper around the fixed-latency fsqrt
// pipeline. Each accepted operand goes to fsqrt and is classified. A shadow
// pipe tracks the operand's tag and class until fsqrt's result is due. The
// result is then fixed up for IEEE special cases and pushed into an in-order
// result FIFO.
//
// Ports
//   clk, rstn            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_ready is registered)
//   in_x, in_tag         : IEEE-754 single operand and its opaque tag
//   sq_x                 : operand to fsqrt.x (zero when nothing is accepted)
//   sq_y                 : result from fsqrt.y, sampled when its op is due
//   out_valid/out_ready  : result handshake (FIFO head)
//   out_y, out_tag       : fixed-up result and its tag
//   out_invalid          : IEEE invalid-operation flag of the head
//
// Timing: an op accepted in cycle t is captured from sq_y in cycle t+LAT-1
// and is visible on the outputs from cycle t+LAT. LAT must be at least 2.
module fsqrt_stream #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sq_x,
    input  logic [31:0]      sq_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_invalid
);

    // The accept cycle itself is the first stage of the pipe, so only LAT-1
    // registered stages are needed to line up with fsqrt's output.
    localparam int NSTG  = LAT - 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_NEG,
        CLS_INF,
        CLS_NAN
    } cls_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        cls_e             cls;
        logic [31:0]      x;
    } pipe_t;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             invalid;
    } res_t;

    pipe_t            pipe_q [NSTG];
    pipe_t            pipe_d [NSTG];
    res_t             fifo_mem [DEPTH];
    res_t             push_res;
    res_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;     // results sitting in the FIFO
    logic [OCC_W-1:0] occ_q, occ_d;     // in flight plus buffered
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             pop;
    logic             push;
    cls_e             in_cls;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = pipe_q[NSTG-1].valid;
    assign sq_x      = accept ? in_x : 32'd0;

    // Classification order matters: NaN wins over the sign test, and zero
    // (including denormals) wins over the sign test too.
    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        in_cls = CLS_NORM;
        if (in_x[30:23] == 8'hFF && in_x[22:0] != '0) begin
            in_cls = CLS_NAN;
        end else if (in_x[30:23] == 8'h00) begin
            in_cls = CLS_ZERO;
        end else if (in_x[31]) begin
            in_cls = CLS_NEG;
        end else if (in_x[30:23] == 8'hFF) begin
            in_cls = CLS_INF;
        end
    end

    // Shadow pipe and special-case fixup of the op leaving it.
    always_comb begin
        pipe_d[0] = '{valid: accept, tag: in_tag, cls: in_cls, x: in_x};
        for (int i = 1; i < NSTG; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        push_res.tag     = pipe_q[NSTG-1].tag;
        push_res.y       = sq_y;
        push_res.invalid = 1'b0;
        unique case (pipe_q[NSTG-1].cls)
            CLS_ZERO: push_res.y = {pipe_q[NSTG-1].x[31], 31'd0};
            CLS_NEG: begin
                push_res.y       = 32'h7FC0_0000;
                push_res.invalid = 1'b1;
            end
            CLS_INF:  push_res.y = 32'h7F80_0000;
            CLS_NAN:  push_res.y = pipe_q[NSTG-1].x | 32'h0040_0000;
            default:  push_res.y = sq_y;
        endcase
    end

    // Pointers and counters. Space for a result is reserved at accept time
    // through occ, so a push never finds the FIFO full.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase

        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        in_ready_d = (occ_d < OCC_W'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSTG; i++) begin
                pipe_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever read after
    // it has been written, and the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_res;
        end
    end

    assign head        = fifo_mem[rd_ptr_q];
    assign out_y       = out_valid ? head.y       : 32'd0;
    assign out_tag     = out_valid ? head.tag     : '0;
    assign out_invalid = out_valid ? head.invalid : 1'b0;

endmodule

// File: tb/tb_fsqrt_stream.sv
// Self-checking bench for fsqrt_stream. A behavioural fsqrt stand-in returns
// (x ^ 32'h5A5A5A5A) so that results are predictable. A scoreboard queue holds
// the expected result of every accepted op. It is computed from the IEEE fixup
// rules and is compared on every pop. Directed sequences cover reset, latency,
// special operands, backpressure, simultaneous accept/pop and reset mid-flight.
// Random traffic follows.
module tb_fsqrt_stream;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      sq_x;
    logic [31:0]      sq_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_invalid;

    int n_checks = 0;
    int n_errors = 0;

    fsqrt_stream #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_tag     (in_tag),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_tag    (out_tag),
        .out_invalid(out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fsqrt stand-in (no reset, like the real core). The operand presented in
    // cycle t produces its result on sq_y in cycle t+LAT-1, which is when the
    // wrapper captures it.
    logic [31:0] sq_dly [LAT-1];
    always @(posedge clk) begin
        sq_dly[0] <= sq_x ^ 32'h5A5A_5A5A;
        for (int i = 1; i < LAT - 1; i++) sq_dly[i] <= sq_dly[i-1];
    end
    assign sq_y = sq_dly[LAT-2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference for the wrapper output, built from the IEEE rules.
    function automatic void ref_result(input logic [31:0] x, output logic [31:0] y,
                                       output logic inv);
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        s = x[31]; e = x[30:23]; m = x[22:0];
        inv = 1'b0;
        if (e == 8'd255 && m != 0)  y = x | 32'h0040_0000;
        else if (e == 8'd0)         y = {s, 31'd0};
        else if (s) begin           y = 32'h7FC0_0000; inv = 1'b1; end
        else if (e == 8'd255)       y = 32'h7F80_0000;
        else                        y = x ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom_range(1, 32'h7F_FFFF));
        case ($urandom_range(0, 7))
            0:       return {s, 8'd0, 23'($urandom)};
            1:       return {1'b1, 8'($urandom_range(1, 254)), m};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, m};
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             inv;
    } exp_t;

    exp_t sb[$];
    logic prev_rstn = 1'b0;
    logic mon_acc;
    logic mon_pop;

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            prev_rstn = 1'b0;
        end else begin
            exp_t e;
            if (prev_rstn) check("in_ready_vs_occ", in_ready, 32'(sb.size() < DEPTH));
            mon_acc = in_valid && in_ready;
            mon_pop = out_valid && out_ready;
            check("sq_x", sq_x, mon_acc ? in_x : 32'd0);
            if (mon_pop) begin
                if (sb.size() == 0) begin
                    check("sb_pop_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_y", out_y, e.y);
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                    check("sb_inv", 32'(out_invalid), 32'(e.inv));
                end
            end
            if (mon_acc) begin
                ref_result(in_x, e.y, e.inv);
                e.tag = in_tag;
                sb.push_back(e);
            end
            prev_rstn = 1'b1;
        end
    end

    task automatic drive(input logic v, input logic [31:0] x, input logic [TAG_W-1:0] t,
                         input logic rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_x      = x;
        in_tag    = t;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) drive(1'b0, 32'd0, '0, 1'b1);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // One op in cycle 0; the result must appear in cycle LAT for one cycle.
    task automatic single_op(input logic [31:0] x, input logic [TAG_W-1:0] t,
                             input logic [31:0] exp_y, input logic exp_inv);
        int          first;
        int          nvalid;
        logic [31:0] y;
        logic [TAG_W-1:0] tg;
        logic        inv;
        first = -1; nvalid = 0; y = '0; tg = '0; inv = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(k == 0, x, t, 1'b1);
            if (out_valid) begin
                nvalid++;
                if (first < 0) begin
                    first = k; y = out_y; tg = out_tag; inv = out_invalid;
                end
            end
        end
        check("single_latency", 32'(first), 32'(LAT));
        check("single_y", y, exp_y);
        check("single_tag", 32'(tg), 32'(t));
        check("single_inv", 32'(inv), 32'(exp_inv));
        check("single_once", 32'(nvalid), 32'd1);
    endtask

    logic [31:0] spec_x   [5] = '{32'h8000_0000, 32'hC080_0000, 32'h7F80_0000,
                                  32'h7F80_0001, 32'h0000_0001};
    logic [31:0] spec_y   [5] = '{32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000,
                                  32'h7FC0_0001, 32'h0000_0000};
    logic        spec_inv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int acc;
        int npop;
        in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b0;
        rstn = 1'b1;
        #2 rstn = 1'b0;

        // Reset behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_y", out_y, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_invalid", 32'(out_invalid), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        drive(1'b0, 32'd0, '0, 1'b1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single op.
        single_op(32'h4040_0000, 4'd5, 32'h1A1A_5A5A, 1'b0);

        // Special operands back to back; results on consecutive cycles.
        npop = 0;
        for (int k = 0; k < 13; k++) begin
            drive(k < 5, (k < 5) ? spec_x[k] : 32'd0, TAG_W'(k), 1'b1);
            if (out_valid && npop < 5) begin
                check("spec_cycle", 32'(k), 32'(LAT + npop));
                check("spec_y", out_y, spec_y[npop]);
                check("spec_inv", 32'(out_invalid), 32'(spec_inv[npop]));
                check("spec_tag", 32'(out_tag), 32'(npop));
                npop++;
            end
        end
        check("spec_count", 32'(npop), 32'd5);

        // Backpressure: six offers, only DEPTH accepted.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h3F80_0000 + 32'(acc << 4), TAG_W'(acc), 1'b0);
            if (in_valid && in_ready) acc++;
        end
        drive(1'b0, 32'd0, '0, 1'b0);
        check("bp_accepted", 32'(acc), 32'(DEPTH));
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        repeat (3) drive(1'b0, 32'd0, '0, 1'b0);
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'd0, '0, 1'b1);
            if (k == 0) check("bp_ready_pop_cycle", 32'(in_ready), 32'd0);
            if (k == 1) check("bp_ready_after_pop", 32'(in_ready), 32'd1);
            if (out_valid) begin
                check("bp_tag_order", 32'(out_tag), 32'(npop));
                npop++;
            end
        end
        check("bp_pops", 32'(npop), 32'(DEPTH));
        drain();

        // Simultaneous accept and pop at occ=3.
        for (int k = 0; k < 3; k++) drive(1'b1, 32'h4100_0000 + 32'(k), TAG_W'(k), 1'b0);
        repeat (4) drive(1'b0, 32'd0, '0, 1'b0);
        drive(1'b1, 32'h4120_0000, 4'd3, 1'b1);
        check("sim_in_ready", 32'(in_ready), 32'd1);
        check("sim_out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 32'd0, '0, 1'b0);
        check("sim_ready_kept", 32'(in_ready), 32'd1);
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h4140_0000 + 32'(acc), TAG_W'(4 + acc), 1'b0);
            if (in_valid && in_ready) acc++;
        end
        check("sim_occ3_one_slot", 32'(acc), 32'd1);
        check("sim_full", 32'(in_ready), 32'd0);
        drain();

        // Random valid/ready traffic against the scoreboard.
        for (int k = 0; k < 100; k++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_operand(), TAG_W'($urandom),
                  1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset mid-flight.
        drive(1'b1, 32'h4080_0000, 4'd9, 1'b1);
        drive(1'b1, 32'h4090_0000, 4'd10, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 32'd0, '0, 1'b1);
            if (out_valid) npop++;
        end
        check("mid_rst_no_output", 32'(npop), 32'd0);
        single_op(32'h4110_0000, 4'd7, 32'h4110_0000 ^ 32'h5A5A_5A5A, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
